// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised multi-port integer register file (RV32I).
//               Registered reads on NRD ports, one write port, x0 hardwired
//               to zero, sequential clear engine that zeroes x1..x(NREG-1)
//               after reset and on an i_clr pulse.
//               Optional macro REGFILE_BYPASS_EN enables same-edge
//               write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_dat,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [XLEN-1:0]     i_wr_dat,
    input  logic                i_clr,
    output logic                o_busy
);

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_CLEAR = 1'b1;
    localparam logic [AW-1:0] C_FIRST = AW'(1);
    localparam logic [AW-1:0] C_LAST  = AW'(NREG - 1);

    logic [0:0]          r_state;
    logic [AW-1:0]       r_cnt;
    logic                w_busy;
    logic                w_wr_acc;
    logic [XLEN-1:0]     w_regs   [0:NREG-1];
    logic [XLEN-1:0]     w_rd_val [0:NRD-1];
    logic [NRD*XLEN-1:0] r_rd_dat;

    assign w_busy   = (r_state == S_CLEAR);
    assign o_busy   = w_busy;
    // A clear request or an active clear always wins over a write; x0 is never written.
    assign w_wr_acc = i_wr_en && !w_busy && !i_clr && (i_wr_addr != '0);

    // Clear engine: walks cnt from 1 to NREG-1, restarting on reset or i_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= C_FIRST;
        end else if (r_state == S_IDLE) begin
            if (i_clr) begin
                r_state <= S_CLEAR;
                r_cnt   <= C_FIRST;
            end
        end else begin
            if (i_clr) begin
                r_cnt <= C_FIRST;
            end else if (r_cnt == C_LAST) begin
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt + AW'(1);
            end
        end
    end

    assign w_regs[0] = '0;

    generate
        for (genvar k = 1; k < NREG; k++) begin : g_reg
            localparam logic [AW-1:0] C_IDX = AW'(k);
            logic [XLEN-1:0] r_q;

            // Storage flop: the clear engine has priority over the write port.
            always_ff @(posedge clk) begin
                if (w_busy && (r_cnt == C_IDX)) begin
                    r_q <= '0;
                end else if (w_wr_acc && (i_wr_addr == C_IDX)) begin
                    r_q <= i_wr_dat;
                end
            end

            assign w_regs[k] = r_q;
        end
    endgenerate

    // Per-port read mux, optionally forwarding the write accepted this edge.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_rd_val[p] = w_regs[i_rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_acc && (i_wr_addr == i_rd_addr[p*AW +: AW])) begin
                w_rd_val[p] = i_wr_dat;
            end
`endif
        end
    end

    // Registered read ports, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_dat <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                r_rd_dat[p*XLEN +: XLEN] <= w_rd_val[p];
            end
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Self-checking bench for reg_file_mp (XLEN=32, NREG=32, NRD=2).
//               Expected values follow REGFILE_BYPASS_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit C_BYP = 1'b1;
`else
    localparam bit C_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  i_rd_addr = '0;
    logic [63:0] o_rd_dat;
    logic        i_wr_en = 1'b0;
    logic [4:0]  i_wr_addr = '0;
    logic [31:0] i_wr_dat = '0;
    logic        i_clr = 1'b0;
    logic        o_busy;

    int n_pass = 0;
    int n_tot  = 0;

    reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_rd_addr (i_rd_addr),
        .o_rd_dat  (o_rd_dat),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_dat  (i_wr_dat),
        .i_clr     (i_clr),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vt [0:9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        i_rd_addr = {a1, a0};
    endtask

    // Counts edges while o_busy stays high (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (o_busy && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic read_all_zero(input string name);
        int bad;
        bad = 0;
        for (int k = 1; k < 32; k++) begin
            set_rd(5'(k), 5'(32 - k));
            step();
            if (o_rd_dat[31:0] !== 32'h0 || o_rd_dat[63:32] !== 32'h0) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int nz;

        // ---------------- reset then idle ----------------
        repeat (3) step();
        chk("rst_busy", {31'd0, o_busy}, 32'd1);
        chk("rst_rd", o_rd_dat[31:0] | o_rd_dat[63:32], 32'd0);
        rst = 1'b0;
        n  = 0;
        nz = 0;
        while (o_busy && n < 100) begin
            step();
            n++;
            if (o_rd_dat !== 64'h0) nz++;
        end
        chk("rst_clear_len", 32'(n), 32'd31);
        chk("rst_clear_rd0", 32'(nz), 32'd0);
        read_all_zero("rst_readback");

        // ---------------- table-driven vectors ----------------
        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  C_BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
        vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF};
        vt[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vt[4] = '{1'b1, 5'd7,  32'h1,        5'd7,  5'd5,  C_BYP ? 32'h1 : 32'h0, 32'hDEADBEEF};
        vt[5] = '{1'b1, 5'd7,  32'h2,        5'd7,  5'd7,  C_BYP ? 32'h2 : 32'h1, C_BYP ? 32'h2 : 32'h1};
        vt[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd6,  32'h2, 32'h0};
        vt[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,  C_BYP ? 32'hFFFFFFFF : 32'h0, 32'h0};
        vt[8] = '{1'b1, 5'd1,  32'h11,       5'd31, 5'd1,  32'hFFFFFFFF, C_BYP ? 32'h11 : 32'h0};
        vt[9] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h11, 32'hFFFFFFFF};
        for (int v = 0; v < 10; v++) begin
            i_wr_en   = vt[v].we;
            i_wr_addr = vt[v].wa;
            i_wr_dat  = vt[v].wd;
            set_rd(vt[v].ra0, vt[v].ra1);
            step();
            chk($sformatf("vec%0d_p0", v), o_rd_dat[31:0],  vt[v].e0);
            chk($sformatf("vec%0d_p1", v), o_rd_dat[63:32], vt[v].e1);
        end
        i_wr_en = 1'b0;

        // ---------------- clear with collision ----------------
        for (int k = 1; k < 32; k++) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 5'(k);
            i_wr_dat  = 32'hA5A5A5A5;
            step();
        end
        i_wr_en = 1'b0;
        set_rd(5'd3, 5'd31);
        step();
        chk("fill_x3", o_rd_dat[31:0], 32'hA5A5A5A5);
        chk("fill_x31", o_rd_dat[63:32], 32'hA5A5A5A5);
        i_clr     = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_addr = 5'd3;
        i_wr_dat  = 32'h5;
        step();
        i_clr   = 1'b0;
        i_wr_en = 1'b0;
        chk("clr_busy_start", {31'd0, o_busy}, 32'd1);
        n = 0;
        while (o_busy && n < 100) begin
            if (n == 10) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 5'd2;
                i_wr_dat  = 32'h77;
            end
            step();
            i_wr_en = 1'b0;
            n++;
            if (n == 1) chk("clr_drop_x3", o_rd_dat[31:0], 32'hA5A5A5A5);
            if (n == 2) chk("clr_stale_x31", o_rd_dat[63:32], 32'hA5A5A5A5);
        end
        chk("clr_len", 32'(n), 32'd31);
        read_all_zero("clr_readback");

        // ---------------- reset mid-clear ----------------
        i_wr_en   = 1'b1;
        i_wr_addr = 5'd25;
        i_wr_dat  = 32'hCAFE;
        step();
        i_wr_en = 1'b0;
        set_rd(5'd25, 5'd0);
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        repeat (9) step();   // cnt has advanced 1 -> 10
        chk("mid_stale_x25", o_rd_dat[31:0], 32'hCAFE);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_async_rd", o_rd_dat[31:0], 32'h0);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd1);
        step();
        step();
        rst = 1'b0;
        count_busy(n);
        chk("mid_rst_len", 32'(n), 32'd31);
        read_all_zero("mid_rst_readback");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
